// File: rtl/opnd_skid_reg_pkg.sv
// Shared types and default widths for the operand skid register stage.
// State encoding and widths used by opnd_skid_reg and its entry registers.
package opnd_skid_reg_pkg;

  localparam int OPND_WIDTH = 16;
  localparam int OPND_TAG_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } opnd_state_e;

endpackage

// File: rtl/opnd_entry_reg.sv
// Load-enabled storage for one operand entry {A, B, tag}.
// Synchronous active-low reset clears the entry.
module opnd_entry_reg
  import opnd_skid_reg_pkg::*;
#(
  parameter int W = 2 * OPND_WIDTH + OPND_TAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/opnd_skid_reg.sv
// Operand register stage into execute with a one-entry skid buffer.
// Optional stall counter output enabled by OPND_STALL_CNT_EN.
module opnd_skid_reg
  import opnd_skid_reg_pkg::*;
#(
  parameter int WIDTH = OPND_WIDTH,
  parameter int TAG_W = OPND_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [TAG_W-1:0] out_tag
`ifdef OPND_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int EW = 2 * WIDTH + TAG_W;

  opnd_state_e r_state;
  opnd_state_e w_nxt;
  logic        w_ld_main;
  logic        w_ld_skid;
  logic [EW-1:0] w_in_ent;
  logic [EW-1:0] w_main_d;
  logic [EW-1:0] w_main_q;
  logic [EW-1:0] w_skid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Flush drops both entries and any incoming operand.
  always_comb begin
    w_nxt     = r_state;
    w_ld_main = 1'b0;
    w_ld_skid = 1'b0;
    if (flush) begin
      w_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (in_valid) begin
            w_ld_main = 1'b1;
            w_nxt     = FULL;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            w_ld_main = 1'b1;
          end else if (!in_valid && out_ready) begin
            w_nxt = EMPTY;
          end else if (in_valid && !out_ready) begin
            w_ld_skid = 1'b1;
            w_nxt     = SKID;
          end
        end
        SKID: begin
          if (out_ready) begin
            w_ld_main = 1'b1;
            w_nxt     = FULL;
          end
        end
        default: w_nxt = EMPTY;
      endcase
    end
  end

  assign w_in_ent = {in_a, in_b, in_tag};
  assign w_main_d = (r_state == SKID) ? w_skid_q : w_in_ent;

  opnd_entry_reg #(.W(EW)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ld_main),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  opnd_entry_reg #(.W(EW)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ld_skid),
    .i_d    (w_in_ent),
    .o_q    (w_skid_q)
  );

  assign {out_a, out_b, out_tag} = w_main_q;
  assign out_valid = (r_state != EMPTY);
  assign in_ready  = (r_state != SKID);

`ifdef OPND_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
